// File: rtl/itcm_auto_loader_pkg.sv
// itcm_auto_loader_pkg: platform widths, default image/ITCM bases and the word-address helper.
`ifndef TOP_DEFINES_VH
`define TOP_DEFINES_VH
`define AXI_ADDR_WIDTH 32
`define AXI_DATA_WIDTH 32
`define DATA_WIDTH 32
`define ITCM_START_ADDR 32'h0000_0000
`define FLASH_START_ADDR 32'h0000_0000
`endif

package itcm_auto_loader_pkg;
    localparam int AXI_ADDR_WIDTH = `AXI_ADDR_WIDTH;
    localparam int AXI_DATA_WIDTH = `AXI_DATA_WIDTH;
    localparam int DATA_WIDTH = `DATA_WIDTH;
    localparam logic [AXI_ADDR_WIDTH-1:0] ITCM_START_ADDR = `ITCM_START_ADDR;
    localparam logic [AXI_ADDR_WIDTH-1:0] FLASH_START_ADDR = `FLASH_START_ADDR;

    // Byte address of 32-bit word idx; wraps modulo 2^AXI_ADDR_WIDTH.
    function automatic logic [AXI_ADDR_WIDTH-1:0] word_addr(
        input logic [AXI_ADDR_WIDTH-1:0] base,
        input logic [AXI_ADDR_WIDTH-1:0] idx
    );
        return base + {idx[AXI_ADDR_WIDTH-3:0], 2'b00};
    endfunction
endpackage

// File: rtl/itcm_auto_loader.sv
// itcm_auto_loader: copies LOAD_WORDS words from flash into the ITCM after reset,
// holding itcm_auto_load high so the decoder and core stay off the ITCM meanwhile.
module itcm_auto_loader
    import itcm_auto_loader_pkg::*;
#(
    parameter logic [AXI_ADDR_WIDTH-1:0] FLASH_BASE = FLASH_START_ADDR,
    parameter logic [AXI_ADDR_WIDTH-1:0] ITCM_BASE = ITCM_START_ADDR,
    parameter int LOAD_WORDS = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      auto_load_en,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    output logic [2:0]                ARPROT,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic [AXI_DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]                RRESP,
    output logic                      itcm_load_wr,
    output logic [AXI_ADDR_WIDTH-1:0] itcm_load_addr,
    output logic [DATA_WIDTH-1:0]     itcm_load_data,
    output logic                      itcm_auto_load,
    output logic                      load_done,
    output logic                      load_error
);
    localparam int IW = $clog2(LOAD_WORDS + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, DONE, ERR} state_t;

    state_t                    state_q;
    logic [IW-1:0]             idx_q;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q, waddr_q;
    logic [DATA_WIDTH-1:0]     wdata_q;
    logic                      arvalid_q, rready_q, wr_q, auto_q, done_q, err_q;
    logic                      last_word;

    assign last_word = idx_q == IW'(LOAD_WORDS - 1);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            araddr_q  <= FLASH_BASE;
            waddr_q   <= ITCM_BASE;
            wdata_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wr_q      <= 1'b0;
            auto_q    <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (auto_load_en) begin
                        state_q   <= ADDR;
                        arvalid_q <= 1'b1;
                    end else begin
                        state_q <= DONE;
                        auto_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        state_q   <= DATA;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                    end
                end
                DATA: begin
                    if (RVALID) begin
                        rready_q <= 1'b0;
                        if (RRESP == 2'b00) begin
                            state_q <= WRITE;
                            wr_q    <= 1'b1;
                            waddr_q <= word_addr(ITCM_BASE, AXI_ADDR_WIDTH'(idx_q));
                            wdata_q <= DATA_WIDTH'(RDATA);
                        end else begin
                            state_q <= ERR;
                            auto_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    wr_q <= 1'b0;
                    if (last_word) begin
                        state_q <= DONE;
                        auto_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        // Next read address is prepared here so ARADDR is stable from the first ADDR cycle.
                        state_q   <= ADDR;
                        idx_q     <= idx_q + 1'b1;
                        araddr_q  <= word_addr(FLASH_BASE, AXI_ADDR_WIDTH'(idx_q) + 1);
                        arvalid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ARVALID        = arvalid_q;
    assign ARADDR         = araddr_q;
    assign ARPROT         = 3'b000;
    assign RREADY         = rready_q;
    assign itcm_load_wr   = wr_q;
    assign itcm_load_addr = waddr_q;
    assign itcm_load_data = wdata_q;
    assign itcm_auto_load = auto_q;
    assign load_done      = done_q;
    assign load_error     = err_q;
endmodule

// File: tb/tb_itcm_auto_loader.sv
// tb_itcm_auto_loader: randomized AXI-lite flash slave driving a 4-word loader and a 1-word loader,
// checked against a transaction-level model of the expected ITCM writes, timing and flags.
module tb_itcm_auto_loader;
    localparam logic [31:0] FB = 32'h1000;
    localparam logic [31:0] FB1 = 32'h2000;
    localparam logic [31:0] IB1 = 32'h40;
    localparam logic [31:0] D1 = 32'hC0FFEE01;

    logic ACLK = 1'b0;
    logic rstn = 1'b0;
    logic auto_en = 1'b1;

    logic arvalid, arready, rvalid, rready, lwr, auto, done, err;
    logic [31:0] araddr, rdata, laddr, ldata;
    logic [2:0] arprot;
    logic [1:0] rresp;

    logic arvalid1, rready1, lwr1, auto1, done1, err1;
    logic [31:0] araddr1, laddr1, ldata1;
    logic [2:0] arprot1;

    logic [31:0] fmem [4];
    int ar_dly [4];
    int r_dly [4];
    logic [1:0] resp [4];

    logic [31:0] wa [$];
    logic [31:0] wd [$];
    int n_arv = 0, n_wr1 = 0, both_hi = 0;
    logic [31:0] wa1 = 0, wd1 = 0;
    int stall_err = 0, stall_seen = 0;
    int n_chk = 0, n_fail = 0;

    always #5 ACLK = ~ACLK;

    itcm_auto_loader #(.FLASH_BASE(FB), .ITCM_BASE(32'h0), .LOAD_WORDS(4)) dut (
        .ACLK(ACLK), .ARESETn(rstn), .auto_load_en(auto_en),
        .ARVALID(arvalid), .ARREADY(arready), .ARADDR(araddr), .ARPROT(arprot),
        .RVALID(rvalid), .RREADY(rready), .RDATA(rdata), .RRESP(rresp),
        .itcm_load_wr(lwr), .itcm_load_addr(laddr), .itcm_load_data(ldata),
        .itcm_auto_load(auto), .load_done(done), .load_error(err)
    );

    itcm_auto_loader #(.FLASH_BASE(FB1), .ITCM_BASE(IB1), .LOAD_WORDS(1)) dut1 (
        .ACLK(ACLK), .ARESETn(rstn), .auto_load_en(auto_en),
        .ARVALID(arvalid1), .ARREADY(1'b1), .ARADDR(araddr1), .ARPROT(arprot1),
        .RVALID(1'b1), .RREADY(rready1), .RDATA(D1), .RRESP(2'b00),
        .itcm_load_wr(lwr1), .itcm_load_addr(laddr1), .itcm_load_data(ldata1),
        .itcm_auto_load(auto1), .load_done(done1), .load_error(err1)
    );

    // Flash slave: accepts an address after ar_dly cycles, answers after r_dly more.
    initial begin
        int ph, cnt, w;
        logic [31:0] hold;
        ph = 0; cnt = 0; w = 0; hold = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge ACLK);
            if (!rstn) begin
                ph = 0; cnt = 0; arready = 0; rvalid = 0;
            end else if (ph == 0) begin
                arready = 0; rvalid = 0; rdata = $urandom;
                if (arvalid) begin
                    if (cnt == 0) hold = araddr;
                    else begin
                        stall_seen++;
                        if (araddr !== hold) stall_err++;
                    end
                    w = int'((araddr - FB) >> 2) & 3;
                    if (cnt >= ar_dly[w]) begin arready = 1; ph = 1; cnt = 0; end
                    else cnt++;
                end
            end else if (ph == 1) begin
                arready = 0;
                if (cnt >= r_dly[w]) begin rvalid = 1; rdata = fmem[w]; rresp = resp[w]; ph = 2; end
                else cnt++;
            end else begin
                rvalid = 0; rdata = $urandom; rresp = 0; ph = 0; cnt = 0;
            end
        end
    end

    always @(negedge ACLK) begin
        if (lwr) begin wa.push_back(laddr); wd.push_back(ldata); end
        if (arvalid) n_arv++;
        if (arvalid && rready) both_hi++;
        if (lwr1) begin n_wr1++; wa1 = laddr1; wd1 = ldata1; end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rst_arvalid"}, 32'(arvalid), 0);
        check({tag, "_rst_rready"}, 32'(rready), 0);
        check({tag, "_rst_wr"}, 32'(lwr), 0);
        check({tag, "_rst_done"}, 32'(done), 0);
        check({tag, "_rst_err"}, 32'(err), 0);
        check({tag, "_rst_auto"}, 32'(auto), 1);
        check({tag, "_rst_araddr"}, araddr, FB);
        check({tag, "_rst_arprot"}, 32'(arprot), 0);
        check({tag, "_rst_laddr"}, laddr, 0);
        check({tag, "_rst_ldata"}, ldata, 0);
        check({tag, "_rst_auto1"}, 32'(auto1), 1);
        check({tag, "_rst_laddr1"}, laddr1, IB1);
    endtask

    task automatic run_case(input bit en, input bit mid, input string tag);
        int exp_cyc, exp_n, exp_arv, exp_stall, b, barv, bst, bw1, c4, c1, k;
        bit exp_err;
        exp_cyc = 1; exp_n = 0; exp_err = 0; exp_arv = 0; exp_stall = 0;
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                exp_cyc += 2 + ar_dly[i] + r_dly[i];
                exp_arv += 1 + ar_dly[i];
                exp_stall += ar_dly[i];
                if (resp[i] != 2'b00) begin exp_err = 1; break; end
                exp_cyc += 1;
                exp_n++;
            end
        end
        rstn = 0; auto_en = en;
        repeat (2) @(negedge ACLK);
        check_reset(tag);
        b = wa.size(); barv = n_arv; bst = stall_seen; bw1 = n_wr1;
        rstn = 1;
        if (mid) begin
            k = 0;
            while (!(rready && araddr == FB + 8) && k < 200) begin @(negedge ACLK); k++; end
            check({tag, "_mid_reached"}, 32'(k < 200), 1);
            rstn = 0;
            @(negedge ACLK);
            check_reset({tag, "_mid"});
            @(negedge ACLK);
            b = wa.size(); barv = n_arv; bst = stall_seen; bw1 = n_wr1;
            rstn = 1;
        end
        c4 = -1; c1 = -1;
        for (int c = 1; c <= 500 && (c4 < 0 || c1 < 0); c++) begin
            @(negedge ACLK);
            if (!auto && c4 < 0) c4 = c;
            if (!auto1 && c1 < 0) c1 = c;
        end
        check({tag, "_cycles"}, c4, exp_cyc);
        check({tag, "_nwrites"}, wa.size() - b, exp_n);
        for (int i = 0; i < exp_n && b + i < wa.size(); i++) begin
            check($sformatf("%s_waddr%0d", tag, i), wa[b+i], 32'(4 * i));
            check($sformatf("%s_wdata%0d", tag, i), wd[b+i], fmem[i]);
        end
        check({tag, "_done"}, 32'(done), 32'(!exp_err));
        check({tag, "_error"}, 32'(err), 32'(exp_err));
        check({tag, "_auto"}, 32'(auto), 0);
        check({tag, "_arvalid_cycles"}, n_arv - barv, exp_arv);
        check({tag, "_stall_cycles"}, stall_seen - bst, exp_stall);
        if (!mid) begin
            check({tag, "_w1_cycles"}, c1, en ? 4 : 1);
            check({tag, "_w1_nwrites"}, n_wr1 - bw1, 32'(en));
            if (en) begin
                check({tag, "_w1_addr"}, wa1, IB1);
                check({tag, "_w1_data"}, wd1, D1);
            end
        end
        b = wa.size(); barv = n_arv; bw1 = n_wr1;
        repeat (6) @(negedge ACLK);
        check({tag, "_quiet_writes"}, wa.size() - b, 0);
        check({tag, "_quiet_arvalid"}, n_arv - barv, 0);
        check({tag, "_quiet_w1"}, n_wr1 - bw1, 0);
        check({tag, "_sticky_done"}, 32'(done), 32'(!exp_err));
        check({tag, "_sticky_done1"}, 32'(done1), 1);
        check({tag, "_err1"}, 32'(err1), 0);
    endtask

    task automatic plain_cfg();
        for (int i = 0; i < 4; i++) begin
            fmem[i] = 32'hA0 + 32'(i); ar_dly[i] = 0; r_dly[i] = 0; resp[i] = 2'b00;
        end
    endtask

    initial begin
        plain_cfg();
        run_case(1, 0, "zero_wait");
        ar_dly[1] = 3; r_dly[1] = 2;
        run_case(1, 0, "stall_w1");
        plain_cfg(); resp[2] = 2'b10;
        run_case(1, 0, "slverr_w2");
        plain_cfg();
        run_case(0, 0, "skip");
        run_case(1, 1, "mid_reset");
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 4; i++) begin
                fmem[i] = $urandom; ar_dly[i] = $urandom_range(0, 3);
                r_dly[i] = $urandom_range(0, 3); resp[i] = 2'b00;
            end
            if ($urandom_range(0, 3) == 0) resp[$urandom_range(0, 3)] = 2'($urandom_range(1, 3));
            run_case(1, 0, $sformatf("rand%0d", t));
        end
        check("araddr_stable_in_stall", stall_err, 0);
        check("arvalid_rready_exclusive", both_hi, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
